// File: rtl/ice51_defs_pkg.sv
// Shared definitions for the ice51 boot loader: state encodings and the
// default UART timing for a 12 MHz clock at 115200 baud.
package ice51_defs;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  localparam int CLKS_PER_BIT_DEFAULT = 104;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP,
    S_WAIT_HIGH = ST_WAIT_HIGH,
    S_DONE      = ST_DONE
  } ld_state_e;

endpackage

// File: rtl/ice51_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, byte strobe
// and stop-bit framing error. Held in IDLE while i_en is low.
module ice51_uart_rx_byte
  import ice51_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_en,
  input  logic       i_uart_rx,
  output logic       o_rx_s,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_rx_s;
  ld_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  ld_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;

  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_sync1   <= i_uart_rx;
      r_rx_s    <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit_idx;
    w_shift_nxt  = r_shift;
    o_byte_valid = 1'b0;
    o_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en && !r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_MID) begin
          // A line that is high again at mid-start was only a glitch.
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
          o_byte_valid = r_rx_s;
          o_frame_err  = !r_rx_s;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!i_en) w_state_nxt = S_IDLE;
  end

  assign o_rx_s = r_rx_s;
  assign o_byte = r_shift;

endmodule

// File: rtl/ice51_uart_loader.sv
// Boot loader: writes MEM_SIZE received UART bytes into code memory from
// address 0, then raises o_load_done to release the CPU.
module ice51_uart_loader
  import ice51_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int MEM_SIZE     = 512,
  parameter int ADDR_W       = 9
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_load_done,
  output logic              o_frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

  ld_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;

  ld_state_e         w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_rx_en;
  logic              w_rx_s;
  logic              w_byte_valid;
  logic [7:0]        w_byte;
  logic              w_frame_err;

  // The receiver only runs while loading; WAIT_HIGH and DONE hold it idle.
  assign w_rx_en = (r_state == S_IDLE);

  ice51_uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_en        (w_rx_en),
    .i_uart_rx   (i_uart_rx),
    .o_rx_s      (w_rx_s),
    .o_byte_valid(w_byte_valid),
    .o_byte      (w_byte),
    .o_frame_err (w_frame_err)
  );

  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    o_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_byte_valid) begin
          o_mem_we   = 1'b1;
          w_addr_nxt = r_addr + 1'b1;
          if (r_addr == LAST_ADDR) w_state_nxt = S_DONE;
        end else if (w_frame_err) begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      // A held-low line after a bad stop bit must not look like a start bit.
      S_WAIT_HIGH: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      S_DONE: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = w_byte;
  assign o_load_done = (r_state == S_DONE);
  assign o_frame_err = w_frame_err;

endmodule

// File: tb/tb_ice51_uart_loader.sv
// Directed testbench for ice51_uart_loader with a 4-byte code memory.
module tb_ice51_uart_loader;

  localparam int CPB      = 104;
  localparam int MEM_SIZE = 4;
  localparam int ADDR_W   = 2;

  logic              i_clk = 1'b0;
  logic              i_nrst = 1'b1;
  logic              i_uart_rx = 1'b1;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_wdata;
  logic              o_load_done;
  logic              o_frame_err;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [7:0]        wr_data[$];
  int                ferr_cnt = 0;
  int                we_long = 0;
  logic              we_prev = 1'b0;

  ice51_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .MEM_SIZE    (MEM_SIZE),
    .ADDR_W      (ADDR_W)
  ) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_uart_rx  (i_uart_rx),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_load_done(o_load_done),
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  // Log writes and error pulses on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (!i_nrst) begin
      if (o_mem_we) begin
        wr_addr.push_back(o_mem_addr);
        wr_data.push_back(o_mem_wdata);
      end
      if (o_frame_err) ferr_cnt++;
      if (o_mem_we && we_prev) we_long++;
      we_prev = o_mem_we;
    end else begin
      we_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bitc, input logic stop_v);
    i_uart_rx = 1'b0;
    tick(bitc);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      tick(bitc);
    end
    i_uart_rx = stop_v;
    tick(bitc);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_nrst = 1'b1;
    i_uart_rx = 1'b1;
    tick(3);
    i_nrst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    tick(3);
    checks += 5;
    if (o_mem_we !== 1'b0)    begin errors++; $display("FAIL reset_we got %b want 0", o_mem_we); end
    if (o_mem_addr !== '0)    begin errors++; $display("FAIL reset_addr got %0d want 0", o_mem_addr); end
    if (o_mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata got %h want 00", o_mem_wdata); end
    if (o_load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_load_done); end
    if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", o_frame_err); end
    i_nrst = 1'b0;
    tick(2);
  endtask

  task automatic test_load();
    logic [7:0] exp[4] = '{8'h02, 8'hA5, 8'h00, 8'hFF};
    int w0 = wr_data.size();
    int f0 = ferr_cnt;
    int l0 = we_long;
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(exp[i], CPB, 1'b1);
    tick(5);
    checks++;
    if (o_load_done !== 1'b0) begin errors++; $display("FAIL load_done_early got %b want 0", o_load_done); end
    send_byte(exp[3], CPB, 1'b1);
    tick(5);
    checks++;
    if (wr_data.size() - w0 != 4) begin errors++; $display("FAIL load_count got %0d want 4", wr_data.size() - w0); end
    for (int i = 0; i < 4; i++) begin
      if (w0 + i < wr_data.size()) begin
        checks += 2;
        if (wr_addr[w0+i] !== ADDR_W'(i)) begin errors++; $display("FAIL load_addr%0d got %0d want %0d", i, wr_addr[w0+i], i); end
        if (wr_data[w0+i] !== exp[i])     begin errors++; $display("FAIL load_data%0d got %h want %h", i, wr_data[w0+i], exp[i]); end
      end
    end
    checks += 3;
    if (o_load_done !== 1'b1) begin errors++; $display("FAIL load_done got %b want 1", o_load_done); end
    if (ferr_cnt != f0)       begin errors++; $display("FAIL load_ferr got %0d want 0", ferr_cnt - f0); end
    if (we_long != l0)        begin errors++; $display("FAIL load_we_width got %0d long pulses want 0", we_long - l0); end
  endtask

  task automatic test_done_lock();
    int w0 = wr_data.size();
    send_byte(8'h77, CPB, 1'b1);
    tick(20);
    checks += 2;
    if (wr_data.size() != w0) begin errors++; $display("FAIL lock_writes got %0d want 0", wr_data.size() - w0); end
    if (o_load_done !== 1'b1) begin errors++; $display("FAIL lock_done got %b want 1", o_load_done); end
  endtask

  task automatic test_glitch();
    int w0;
    int f0;
    do_reset();
    w0 = wr_data.size();
    f0 = ferr_cnt;
    i_uart_rx = 1'b0;
    tick(20);
    i_uart_rx = 1'b1;
    tick(3 * CPB);
    checks += 2;
    if (wr_data.size() != w0) begin errors++; $display("FAIL glitch_writes got %0d want 0", wr_data.size() - w0); end
    if (ferr_cnt != f0)       begin errors++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - f0); end
    send_byte(8'h3C, CPB, 1'b1);
    tick(5);
    checks++;
    if (wr_data.size() - w0 != 1) begin
      errors++; $display("FAIL glitch_count got %0d want 1", wr_data.size() - w0);
    end else begin
      checks += 2;
      if (wr_addr[w0] !== '0)    begin errors++; $display("FAIL glitch_addr got %0d want 0", wr_addr[w0]); end
      if (wr_data[w0] !== 8'h3C) begin errors++; $display("FAIL glitch_data got %h want 3c", wr_data[w0]); end
    end
  endtask

  task automatic test_frame_err();
    int w0;
    int f0;
    do_reset();
    w0 = wr_data.size();
    f0 = ferr_cnt;
    send_byte(8'h55, CPB, 1'b0);
    tick(3 * CPB);
    i_uart_rx = 1'b1;
    tick(CPB);
    send_byte(8'h66, CPB, 1'b1);
    tick(5);
    checks += 2;
    if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0); end
    if (wr_data.size() - w0 != 1) begin
      errors++; $display("FAIL ferr_count got %0d want 1", wr_data.size() - w0);
    end else begin
      checks += 2;
      if (wr_addr[w0] !== '0)    begin errors++; $display("FAIL ferr_addr got %0d want 0", wr_addr[w0]); end
      if (wr_data[w0] !== 8'h66) begin errors++; $display("FAIL ferr_data got %h want 66", wr_data[w0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int w0;
    do_reset();
    w0 = wr_data.size();
    send_byte(8'h11, CPB, 1'b1);
    send_byte(8'h22, CPB, 1'b1);
    checks++;
    if (wr_data.size() - w0 != 2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", wr_data.size() - w0); end
    i_uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      i_uart_rx = i[0];
      tick(CPB);
    end
    i_nrst = 1'b1;
    tick(2);
    checks += 5;
    if (o_mem_we !== 1'b0)    begin errors++; $display("FAIL mid_rst_we got %b want 0", o_mem_we); end
    if (o_mem_addr !== '0)    begin errors++; $display("FAIL mid_rst_addr got %0d want 0", o_mem_addr); end
    if (o_mem_wdata !== 8'h0) begin errors++; $display("FAIL mid_rst_wdata got %h want 00", o_mem_wdata); end
    if (o_load_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", o_load_done); end
    if (o_frame_err !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr got %b want 0", o_frame_err); end
    i_uart_rx = 1'b1;
    tick(5);
    i_nrst = 1'b0;
    tick(5);
    w0 = wr_data.size();
    for (int i = 0; i < 3; i++) send_byte(exp[i], CPB, 1'b1);
    tick(5);
    checks++;
    if (o_load_done !== 1'b0) begin errors++; $display("FAIL mid_done_early got %b want 0", o_load_done); end
    send_byte(exp[3], CPB, 1'b1);
    tick(5);
    checks += 2;
    if (wr_data.size() - w0 != 4) begin errors++; $display("FAIL mid_count got %0d want 4", wr_data.size() - w0); end
    if (o_load_done !== 1'b1)     begin errors++; $display("FAIL mid_done got %b want 1", o_load_done); end
    for (int i = 0; i < 4; i++) begin
      if (w0 + i < wr_data.size()) begin
        checks += 2;
        if (wr_addr[w0+i] !== ADDR_W'(i)) begin errors++; $display("FAIL mid_addr%0d got %0d want %0d", i, wr_addr[w0+i], i); end
        if (wr_data[w0+i] !== exp[i])     begin errors++; $display("FAIL mid_data%0d got %h want %h", i, wr_data[w0+i], exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[4] = '{8'h81, 8'h81, 8'h12, 8'h34};
    int w0;
    do_reset();
    w0 = wr_data.size();
    send_byte(8'h81, 106, 1'b1);
    tick(CPB);
    send_byte(8'h81, 102, 1'b1);
    tick(CPB);
    send_byte(8'h12, CPB, 1'b1);
    send_byte(8'h34, CPB, 1'b1);
    tick(5);
    checks += 2;
    if (wr_data.size() - w0 != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", wr_data.size() - w0); end
    if (o_load_done !== 1'b1)     begin errors++; $display("FAIL b2b_done got %b want 1", o_load_done); end
    for (int i = 0; i < 4; i++) begin
      if (w0 + i < wr_data.size()) begin
        checks += 2;
        if (wr_addr[w0+i] !== ADDR_W'(i)) begin errors++; $display("FAIL b2b_addr%0d got %0d want %0d", i, wr_addr[w0+i], i); end
        if (wr_data[w0+i] !== exp[i])     begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, wr_data[w0+i], exp[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_done_lock();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
